// File: rtl/riscv_pkg.sv
// riscv_pkg: writeback select encoding, load funct3 codes and WB FSM states
package riscv_pkg;
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_WAIT_LD
    } wb_state_e;
endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte/half/word, extends it and flags misaligned or reserved loads
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            err_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // extend per load type; halfword loads ignore addr_lo[0] since that case is an error
    always_comb begin
        data_o = rdata_i;
        err_o  = 1'b0;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   begin
                data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
                err_o  = addr_lo_i[0];
            end
            F3_LHU:  begin
                data_o = {{(XLEN-16){1'b0}}, half_sel};
                err_o  = addr_lo_i[0];
            end
            F3_LW:   err_o = |addr_lo_i;
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage driving the regfile write port and the retired-instruction counter
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic             rd_wr_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [1:0]       wb_sel_i,
    input  logic [XLEN-1:0]  alu_data_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [2:0]       ld_funct3_i,
    input  logic [1:0]       ld_addr_lo_i,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic             rd_wr_o,
    output logic [4:0]       rd_addr_o,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instret_o
);
    wb_state_e        state_q;
    logic             ld_wr_q;
    logic [4:0]       ld_rd_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_lo_q;
    logic             rd_wr_q;
    logic [4:0]       rd_addr_q;
    logic [XLEN-1:0]  rd_data_q;
    logic             err_q;
    logic [CNT_W-1:0] instret_q;

    logic             xfer;
    logic             ex_wr_d;
    logic [XLEN-1:0]  ex_data_d;
    logic             ld_wr_d;
    logic [XLEN-1:0]  ld_data;
    logic             ld_err;
    logic [CNT_W-1:0] instret_d;

    assign mem_ready_o = (state_q == S_IDLE);
    assign xfer        = mem_valid_i & mem_ready_o;
    assign ex_data_d   = (wb_sel_i == WB_PC4) ? pc_i + XLEN'(4) : alu_data_i;
    assign ex_wr_d     = rd_wr_i & (rd_addr_i != 5'd0);
    assign ld_wr_d     = ld_wr_q & (ld_rd_q != 5'd0) & ~ld_err;
    assign instret_d   = instret_q + CNT_W'(1);

    load_align #(.XLEN(XLEN)) u_align (
        .funct3_i  (ld_f3_q),
        .addr_lo_i (ld_lo_q),
        .rdata_i   (dmem_rdata_i),
        .data_o    (ld_data),
        .err_o     (ld_err)
    );

    // FSM with registered write port: strobes default low, address/data hold unless written
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ld_wr_q   <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_lo_q   <= '0;
            rd_wr_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            rd_wr_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (xfer && wb_sel_i == WB_LOAD) begin
                        ld_wr_q <= rd_wr_i;
                        ld_rd_q <= rd_addr_i;
                        ld_f3_q <= ld_funct3_i;
                        ld_lo_q <= ld_addr_lo_i;
                        state_q <= S_WAIT_LD;
                    end else if (xfer) begin
                        rd_wr_q   <= ex_wr_d;
                        instret_q <= instret_d;
                        if (ex_wr_d) begin
                            rd_addr_q <= rd_addr_i;
                            rd_data_q <= ex_data_d;
                        end
                    end
                end
                S_WAIT_LD: begin
                    if (dmem_rvalid_i) begin
                        rd_wr_q   <= ld_wr_d;
                        err_q     <= ld_err;
                        instret_q <= instret_d;
                        state_q   <= S_IDLE;
                        if (ld_wr_d) begin
                            rd_addr_q <= ld_rd_q;
                            rd_data_q <= ld_data;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_wr_o   = rd_wr_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;
    assign err_o     = err_q;
    assign instret_o = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage, plus a narrow-counter instance for wrap
module tb_wb_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic        rd_wr_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic [1:0]  wb_sel_i = '0;
    logic [31:0] alu_data_i = '0;
    logic [31:0] pc_i = '0;
    logic [2:0]  ld_funct3_i = '0;
    logic [1:0]  ld_addr_lo_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    logic        mem_ready_o, rd_wr_o, err_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [63:0] instret_o;

    logic        w_ready, w_wr, w_err;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [2:0]  w_instret;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .rd_wr_i(rd_wr_i), .rd_addr_i(rd_addr_i), .wb_sel_i(wb_sel_i), .alu_data_i(alu_data_i),
        .pc_i(pc_i), .ld_funct3_i(ld_funct3_i), .ld_addr_lo_i(ld_addr_lo_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rd_wr_o(rd_wr_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .err_o(err_o), .instret_o(instret_o)
    );

    wb_stage #(.XLEN(32), .CNT_W(3)) dut_w (
        .clk_i(clk), .rst_ni(rst_ni), .mem_valid_i(mem_valid_i), .mem_ready_o(w_ready),
        .rd_wr_i(rd_wr_i), .rd_addr_i(rd_addr_i), .wb_sel_i(wb_sel_i), .alu_data_i(alu_data_i),
        .pc_i(pc_i), .ld_funct3_i(ld_funct3_i), .ld_addr_lo_i(ld_addr_lo_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rd_wr_o(w_wr),
        .rd_addr_o(w_addr), .rd_data_o(w_data), .err_o(w_err), .instret_o(w_instret)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          wb_cyc[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          run = 0;
    int          max_run = 0;
    bit          prev_wb = 0;
    bit          allow_stray = 0;
    logic [63:0] last_cnt = '0;
    logic [63:0] retired = '0;
    logic [63:0] base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = (lo == 2'd0) ? w[7:0] : (lo == 2'd1) ? w[15:8] : (lo == 2'd2) ? w[23:16] : w[31:24];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {1'b0, {24{b[7]}}, b};
            3'b001:  return {lo[0], {16{h[15]}}, h};
            3'b010:  return {lo != 2'd0, w};
            3'b100:  return {1'b0, 24'd0, b};
            3'b101:  return {lo[0], 16'd0, h};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr, input logic [4:0] addr, input logic [31:0] data, input logic err);
        exp_t e;
        e.wr = wr; e.addr = addr; e.data = data; e.err = err;
        exp_q.push_back(e);
        retired++;
    endtask

    task automatic drive_ex(input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] expd);
        mem_valid_i = 1'b1; rd_wr_i = wr; rd_addr_i = rd; wb_sel_i = sel; alu_data_i = alu; pc_i = pc;
        push(wr && rd != 5'd0, rd, expd, 1'b0);
    endtask

    task automatic issue_ex(input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] expd);
        drive_ex(wr, rd, sel, alu, pc, expd);
        step();
        mem_valid_i = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                           input logic [31:0] word, input int wait_cyc);
        logic [32:0] m;
        mem_valid_i = 1'b1; rd_wr_i = 1'b1; rd_addr_i = rd; wb_sel_i = WB_LOAD;
        ld_funct3_i = f3; ld_addr_lo_i = lo;
        step();
        mem_valid_i = 1'b0;
        check("ready_in_wait", mem_ready_o, 0);
        for (int i = 0; i < wait_cyc; i++) begin
            step();
            check("ready_still_wait", mem_ready_o, 0);
        end
        m = model_load(f3, lo, word);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = word;
        push(!m[32] && rd != 5'd0, rd, m[31:0], m[32]);
        step();
        dmem_rvalid_i = 1'b0;
        check("ready_after_load", mem_ready_o, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: each instret change is one writeback cycle, compared against the queue head
    always @(negedge clk) begin
        exp_t e;
        bit   wb;
        wb = 0;
        if (!rst_ni) begin
            last_cnt = '0;
            prev_wb  = 0;
        end else begin
            if (dmem_rvalid_i && !allow_stray) check("rvalid_protocol_ready", mem_ready_o, 0);
            if (instret_o !== last_cnt) begin
                wb = 1;
                check("instret_step", instret_o, last_cnt + 64'd1);
                last_cnt = instret_o;
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_wr", rd_wr_o, e.wr);
                    check("sb_err", err_o, e.err);
                    if (e.wr) begin
                        check("sb_addr", rd_addr_o, e.addr);
                        check("sb_data", rd_data_o, e.data);
                    end
                end
                wb_cyc.push_back(cyc);
                run = prev_wb ? run + 1 : 1;
                if (run > max_run) max_run = run;
            end else begin
                check("idle_wr", rd_wr_o, 0);
                check("idle_err", err_o, 0);
            end
            prev_wb = wb;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", rd_wr_o, 0);
        check("rst_addr", rd_addr_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_err", err_o, 0);
        check("rst_instret", instret_o, 0);
        rst_ni = 1'b1;
        step();
        check("ready_idle", mem_ready_o, 1);

        issue_ex(1'b1, 5'd5, WB_ALU, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_wr", rd_wr_o, 1);
        check("t1_addr", rd_addr_o, 5);
        check("t1_data", rd_data_o, 32'hDEADBEEF);
        check("t1_instret", instret_o, 1);
        step();

        do_load(F3_LB, 2'd2, 5'd6, 32'h12F45678, 3);
        @(negedge clk);
        check("lb_data", rd_data_o, 32'hFFFFFFF4);
        step();
        do_load(F3_LBU, 2'd2, 5'd6, 32'h12F45678, 1);
        @(negedge clk);
        check("lbu_data", rd_data_o, 32'h000000F4);
        step();
        do_load(F3_LHU, 2'd2, 5'd7, 32'h8001ABCD, 0);
        do_load(F3_LH, 2'd2, 5'd8, 32'h8001ABCD, 0);
        do_load(F3_LB, 2'd3, 5'd9, 32'h7F000000, 0);

        base = instret_o;
        do_load(F3_LH, 2'd1, 5'd10, 32'hFFFFFFFF, 1);
        @(negedge clk);
        check("mis_err", err_o, 1);
        check("mis_wr", rd_wr_o, 0);
        check("mis_instret", instret_o, base + 64'd1);
        step();
        check("mis_err_pulse", err_o, 0);
        do_load(F3_LW, 2'd2, 5'd11, 32'h01020304, 0);
        do_load(3'b110, 2'd0, 5'd12, 32'h01020304, 0);

        base = instret_o;
        issue_ex(1'b1, 5'd0, WB_ALU, 32'h1234, 32'h0, 32'h1234);
        @(negedge clk);
        check("x0_wr", rd_wr_o, 0);
        check("x0_instret", instret_o, base + 64'd1);
        step();
        issue_ex(1'b1, 5'd1, WB_PC4, 32'h5555, 32'hFFFFFFFC, 32'h00000000);
        @(negedge clk);
        check("jal_wrap", rd_data_o, 32'h00000000);
        step();
        issue_ex(1'b0, 5'd3, WB_ALU, 32'h77, 32'h0, 32'h77);
        issue_ex(1'b1, 5'd4, 2'd3, 32'hCAFE0003, 32'h100, 32'hCAFE0003);
        step();
        step();

        mem_valid_i = 1'b1; rd_wr_i = 1'b1; rd_addr_i = 5'd13; wb_sel_i = WB_LOAD;
        ld_funct3_i = F3_LW; ld_addr_lo_i = 2'd0;
        step();
        mem_valid_i = 1'b0;
        step();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_wr", rd_wr_o, 0);
        check("mid_rst_data", rd_data_o, 0);
        check("mid_rst_addr", rd_addr_o, 0);
        check("mid_rst_instret", instret_o, 0);
        check("mid_rst_ready", mem_ready_o, 1);
        retired = '0;
        step();
        rst_ni = 1'b1;
        allow_stray = 1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0;
        step();
        dmem_rvalid_i = 1'b0;
        step();
        allow_stray = 0;
        check("late_rvalid_wr", rd_wr_o, 0);
        check("late_rvalid_data", rd_data_o, 0);
        check("late_rvalid_instret", instret_o, 0);
        check("late_rvalid_ready", mem_ready_o, 1);

        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            drive_ex(1'b1, 5'(i + 1), WB_ALU, 32'h100 + 32'(i), 32'h0, 32'h100 + 32'(i));
            step();
        end
        mem_valid_i = 1'b0;
        step();
        step();
        check("burst_run", max_run, 8);

        wb_cyc.delete();
        mem_valid_i = 1'b1; rd_wr_i = 1'b1; rd_addr_i = 5'd14; wb_sel_i = WB_LOAD;
        ld_funct3_i = F3_LW; ld_addr_lo_i = 2'd0;
        step();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hA5A5F00D;
        push(1'b1, 5'd14, 32'hA5A5F00D, 1'b0);
        mem_valid_i = 1'b1; rd_wr_i = 1'b1; rd_addr_i = 5'd15; wb_sel_i = WB_ALU; alu_data_i = 32'h0BADF00D;
        check("lw_alu_stall", mem_ready_o, 0);
        step();
        dmem_rvalid_i = 1'b0;
        check("lw_alu_ready", mem_ready_o, 1);
        push(1'b1, 5'd15, 32'h0BADF00D, 1'b0);
        step();
        mem_valid_i = 1'b0;
        step();
        step();
        check("lw_alu_wb_count", 64'(wb_cyc.size()), 2);
        if (wb_cyc.size() == 2) check("lw_alu_gap", 64'(wb_cyc[1] - wb_cyc[0]), 1);

        check("final_instret", instret_o, retired);
        check("wrap_instret", 64'(w_instret), {61'd0, retired[2:0]});
        check("sb_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
